// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-to-level decoder: FSM states,
// error codes and a saturating increment used by the duration counter.
package edge_pkg;

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_BOTH   = 2'd1,
    ERR_DUP    = 2'd2,
    ERR_GLITCH = 2'd3
  } err_code_t;

  // Counters are carried through a 32-bit helper, so widths stay below 32.
  localparam int MAX_CNT_W = 31;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running saturating up-counter with a synchronous clear; clear has
// priority over the increment.
module sat_counter
  import edge_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [31:0] MAX_VALUE = 32'((64'd1 << W) - 64'd1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = W'(sat_inc(32'(count_reg), MAX_VALUE));
    if (clear) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/edge_to_level_decoder.sv
// Rebuilds a level waveform from rise/fall event pulses, reports how long
// each level was held and keeps a sticky record of the first illegal event.
module edge_to_level_decoder
  import edge_pkg::*;
#(
  parameter int   HOLD_MIN   = 2,
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pos_pulse,
  input  logic             neg_pulse,
  input  logic             clear,
  output logic             level,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W-1:0] high_len,
  output logic             len_valid,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [31:0] MAX_LEN     = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [31:0] HOLD_MIN_U  = 32'(HOLD_MIN);
  localparam state_t      RESET_STATE = INIT_LEVEL ? S_HIGH : S_LOW;

  if (CNT_W < 1 || CNT_W > MAX_CNT_W) begin : g_bad_cnt_w
    $error("edge_to_level_decoder: CNT_W must be in 1..31");
  end
  if (HOLD_MIN < 0 || HOLD_MIN > (2 ** CNT_W) - 1) begin : g_bad_hold_min
    $error("edge_to_level_decoder: HOLD_MIN must be in 0..2**CNT_W-1");
  end

  state_t           state_reg;
  logic             level_reg;
  logic [CNT_W-1:0] low_len_reg;
  logic [CNT_W-1:0] high_len_reg;
  logic             len_valid_reg;
  logic             err_reg;
  err_code_t        err_code_reg;

  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] len;
  logic             len_ok;
  logic             accept;
  logic             reject;
  err_code_t        code_next;

  // The counter restarts only on an accepted transition; rejected events
  // fall inside the current period and keep it counting.
  sat_counter #(
    .W(CNT_W)
  ) u_dur_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .count(dur_cnt)
  );

  // Candidate length includes the cycle in which the event is present.
  assign len    = CNT_W'(sat_inc(32'(dur_cnt), MAX_LEN));
  assign len_ok = 32'(len) >= HOLD_MIN_U;

  always_comb begin
    accept    = 1'b0;
    reject    = 1'b0;
    code_next = ERR_NONE;
    if (pos_pulse && neg_pulse) begin
      reject    = 1'b1;
      code_next = ERR_BOTH;
    end else if ((state_reg == S_HIGH && pos_pulse) ||
                 (state_reg == S_LOW && neg_pulse)) begin
      reject    = 1'b1;
      code_next = ERR_DUP;
    end else if (pos_pulse || neg_pulse) begin
      if (len_ok) begin
        accept = 1'b1;
      end else begin
        reject    = 1'b1;
        code_next = ERR_GLITCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET_STATE;
      level_reg     <= INIT_LEVEL;
      low_len_reg   <= '0;
      high_len_reg  <= '0;
      len_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      len_valid_reg <= accept;
      if (accept) begin
        if (state_reg == S_LOW) begin
          state_reg   <= S_HIGH;
          level_reg   <= 1'b1;
          low_len_reg <= len;
        end else begin
          state_reg    <= S_LOW;
          level_reg    <= 1'b0;
          high_len_reg <= len;
        end
      end
      // A new error beats a simultaneous clear; otherwise the first code sticks.
      if (reject) begin
        err_reg <= 1'b1;
        if (!err_reg || clear) begin
          err_code_reg <= code_next;
        end
      end else if (clear) begin
        err_reg      <= 1'b0;
        err_code_reg <= ERR_NONE;
      end
    end
  end

  assign level     = level_reg;
  assign low_len   = low_len_reg;
  assign high_len  = high_len_reg;
  assign len_valid = len_valid_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

endmodule

// File: tb/tb_edge_to_level_decoder.sv
// Scenario bench for edge_to_level_decoder: an 8-bit and a 4-bit instance
// share the event inputs; expected output vectors go through a queue.
module tb_edge_to_level_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pos_pulse = 1'b0;
  logic       neg_pulse = 1'b0;
  logic       clear = 1'b0;

  logic       level;
  logic [7:0] low_len;
  logic [7:0] high_len;
  logic       len_valid;
  logic       err;
  logic [1:0] err_code;

  logic       level4;
  logic [3:0] low_len4;
  logic [3:0] high_len4;
  logic       len_valid4;
  logic       err4;
  logic [1:0] err_code4;

  typedef struct {
    string       name;
    logic [20:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  edge_to_level_decoder #(.HOLD_MIN(2), .CNT_W(8), .INIT_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pos_pulse(pos_pulse), .neg_pulse(neg_pulse),
    .clear(clear), .level(level), .low_len(low_len), .high_len(high_len),
    .len_valid(len_valid), .err(err), .err_code(err_code)
  );

  edge_to_level_decoder #(.HOLD_MIN(2), .CNT_W(4), .INIT_LEVEL(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .pos_pulse(pos_pulse), .neg_pulse(neg_pulse),
    .clear(clear), .level(level4), .low_len(low_len4), .high_len(high_len4),
    .len_valid(len_valid4), .err(err4), .err_code(err_code4)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {level, low_len, high_len, len_valid, err, err_code}
  function automatic logic [20:0] mk(input logic l, input logic [7:0] lo,
                                     input logic [7:0] hi, input logic lv,
                                     input logic e, input logic [1:0] c);
    return {l, lo, hi, lv, e, c};
  endfunction

  function automatic logic [20:0] obs8();
    return {level, low_len, high_len, len_valid, err, err_code};
  endfunction

  function automatic logic [20:0] obs4();
    return {level4, 4'h0, low_len4, 4'h0, high_len4, len_valid4, err4, err_code4};
  endfunction

  function automatic exp_t ex(input string n, input logic [20:0] v);
    exp_t e;
    e.name  = n;
    e.value = v;
    return e;
  endfunction

  // Inputs are applied one time step after an edge and sampled by the next one.
  task automatic cycle(input logic p, input logic n, input logic c);
    pos_pulse = p;
    neg_pulse = n;
    clear     = c;
    @(posedge clk);
    #1;
    pos_pulse = 1'b0;
    neg_pulse = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    exp_t x;
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(ex("reset_dut8", mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    sb.push_back(ex("reset_dut4", mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs4() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs4(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t x;
    test_reset();
    idle(4);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t1_rise_e5", mk(1'b1, 8'd5, 8'd0, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b0, 1'b0, 1'b0);
    sb.push_back(ex("t1_valid_drop", mk(1'b1, 8'd5, 8'd0, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("t1_fall_e9", mk(1'b0, 8'd5, 8'd4, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b0, 1'b0, 1'b0);
    sb.push_back(ex("t1_idle_after", mk(1'b0, 8'd5, 8'd4, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
  endtask

  task automatic test_glitch();
    exp_t x;
    test_reset();
    idle(4);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t2_rise_e5", mk(1'b1, 8'd5, 8'd0, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("t2_glitch_e6", mk(1'b1, 8'd5, 8'd0, 1'b0, 1'b1, 2'd3)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b0, 1'b0, 1'b1);
    sb.push_back(ex("t2_clear", mk(1'b1, 8'd5, 8'd0, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    // High period counts through the rejected glitch: edges 6,7,8 -> 3.
    cycle(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("t2_fall_after_glitch", mk(1'b0, 8'd5, 8'd3, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
  endtask

  task automatic test_both_and_first_error();
    exp_t x;
    test_reset();
    idle(6);
    cycle(1'b1, 1'b1, 1'b0);
    sb.push_back(ex("t3_both_e7", mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 2'd1)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t3_rise_e8", mk(1'b1, 8'd8, 8'd0, 1'b1, 1'b1, 2'd1)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t3_dup_keeps_first", mk(1'b1, 8'd8, 8'd0, 1'b0, 1'b1, 2'd1)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b1, 1'b0, 1'b1);
    sb.push_back(ex("t3_clear_vs_new_err", mk(1'b1, 8'd8, 8'd0, 1'b0, 1'b1, 2'd2)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    cycle(1'b0, 1'b0, 1'b1);
    sb.push_back(ex("t3_clear_only", mk(1'b1, 8'd8, 8'd0, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
  endtask

  task automatic test_dup_and_hold_min();
    exp_t x;
    test_reset();
    idle(2);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t4_rise_e3", mk(1'b1, 8'd3, 8'd0, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t4_dup_e5", mk(1'b1, 8'd3, 8'd0, 1'b0, 1'b1, 2'd2)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("t4_full_high_len", mk(1'b0, 8'd3, 8'd4, 1'b1, 1'b1, 2'd2)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    // Level held exactly HOLD_MIN cycles is accepted.
    idle(1);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t4_len_eq_hold_min", mk(1'b1, 8'd2, 8'd4, 1'b1, 1'b1, 2'd2)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
  endtask

  task automatic test_saturation();
    exp_t x;
    test_reset();
    idle(40);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t5_low_sat_w4", mk(1'b1, 8'd15, 8'd0, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs4() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs4(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    idle(20);
    cycle(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("t5_high_sat_w4", mk(1'b0, 8'd15, 8'd15, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs4() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs4(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
  endtask

  task automatic test_async_reset();
    exp_t x;
    test_reset();
    idle(2);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    sb.push_back(ex("t6_pre_reset", mk(1'b1, 8'd3, 8'd0, 1'b0, 1'b1, 2'd3)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(ex("t6_async_clear", mk(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    cycle(1'b1, 1'b0, 1'b0);
    sb.push_back(ex("t6_rise_after_release", mk(1'b1, 8'd3, 8'd0, 1'b1, 1'b0, 2'd0)));
    x = sb.pop_front(); n_checks++;
    if (obs8() !== x.value) begin n_fail++; $display("FAIL %s: got %h expected %h", x.name, obs8(), x.value); end
    else $display("ok   %s: %h", x.name, x.value);
  endtask

  initial begin
    test_basic();
    test_glitch();
    test_both_and_first_error();
    test_dup_and_hold_min();
    test_saturation();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
